// File: rtl/gate_sweep_pkg.sv
// gate_sweep_pkg: shared state encoding and sizing for the gate sweep sequencer
package gate_sweep_pkg;
  typedef enum logic [1:0] {IDLE, DRIVE, DONE} state_t;
  localparam int NUM_COMBOS = 4;
  localparam int IDX_W = 2;
endpackage

// File: rtl/gate_sweep_ctrl.sv
// gate_sweep_ctrl: drives all four input combinations of a 2-input gate and checks its truth table
module gate_sweep_ctrl
  import gate_sweep_pkg::*;
#(
  parameter int DWELL = 2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  start,
  input  logic                  abort,
  input  logic [NUM_COMBOS-1:0] expected,
  output logic                  gate_a,
  output logic                  gate_b,
  input  logic                  gate_out,
  output logic                  busy,
  output logic                  done,
  output logic [NUM_COMBOS-1:0] table_q,
  output logic [NUM_COMBOS-1:0] mismatch,
  output logic                  pass
);
  localparam int CW = DWELL > 1 ? $clog2(DWELL) : 1;
  if (DWELL < 1) begin : g_dwell_chk
    $error("gate_sweep_ctrl: DWELL must be >= 1");
  end
  state_t state, nxt;
  logic [IDX_W-1:0] idx, idx_d;
  logic [CW-1:0] cnt, cnt_d;
  logic [NUM_COMBOS-1:0] exp_q, tbl_d, mis_d;
  logic acc, smp, fin, pass_d, busy_d, done_d, ga_d, gb_d;
  assign acc = state == IDLE && start && !abort;
  assign smp = state == DRIVE && !abort && cnt == CW'(DWELL - 1);
  assign fin = smp && idx == IDX_W'(NUM_COMBOS - 1);
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) state <= IDLE;
    else state <= nxt;
  always_comb nxt = abort ? IDLE : acc ? DRIVE : fin ? DONE : state == DONE ? IDLE : state;
  // gate inputs follow the next index so each combination appears on the edge it becomes current
  always_comb begin
    idx_d = acc ? '0 : smp && !fin ? idx + 1'b1 : idx;
    cnt_d = acc || smp ? '0 : state == DRIVE && !abort ? cnt + 1'b1 : cnt;
    tbl_d = acc ? '0 : table_q;
    if (smp) tbl_d[idx] = gate_out;
    mis_d = acc ? '0 : fin ? tbl_d ^ exp_q : mismatch;
    pass_d = acc ? 1'b0 : fin ? tbl_d == exp_q : pass;
    busy_d = nxt != IDLE;
    done_d = nxt == DONE;
    ga_d = busy_d & idx_d[0];
    gb_d = busy_d & idx_d[1];
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      idx      <= '0;
      cnt      <= '0;
      exp_q    <= '0;
      table_q  <= '0;
      mismatch <= '0;
      pass     <= 1'b0;
      busy     <= 1'b0;
      done     <= 1'b0;
      gate_a   <= 1'b0;
      gate_b   <= 1'b0;
    end else begin
      idx      <= idx_d;
      cnt      <= cnt_d;
      exp_q    <= acc ? expected : exp_q;
      table_q  <= tbl_d;
      mismatch <= mis_d;
      pass     <= pass_d;
      busy     <= busy_d;
      done     <= done_d;
      gate_a   <= ga_d;
      gate_b   <= gb_d;
    end
endmodule

// File: tb/tb_gate_sweep_ctrl.sv
// tb_gate_sweep_ctrl: directed bench for gate_sweep_ctrl with behavioural AND/OR/XOR gates
module tb_gate_sweep_ctrl;
  logic clk = 0, rst_n = 0, start = 0, start1 = 0, abort = 0;
  logic [3:0] expected = '0;
  logic ga, gb, gout, busy, done, pass;
  logic [3:0] tq, mis;
  logic ga1, gb1, gout1, busy1, done1, pass1;
  logic [3:0] tq1, mis1;
  int gfn = 0;
  int tests = 0, fails = 0;
  always #5 clk = ~clk;
  assign gout = gfn == 0 ? ga & gb : gfn == 1 ? ga | gb : ga ^ gb;
  assign gout1 = ga1 ^ gb1;
  gate_sweep_ctrl #(.DWELL(2)) dut (
    .clk(clk), .rst_n(rst_n), .start(start), .abort(abort), .expected(expected),
    .gate_a(ga), .gate_b(gb), .gate_out(gout), .busy(busy), .done(done),
    .table_q(tq), .mismatch(mis), .pass(pass)
  );
  gate_sweep_ctrl #(.DWELL(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start1), .abort(abort), .expected(expected),
    .gate_a(ga1), .gate_b(gb1), .gate_out(gout1), .busy(busy1), .done(done1),
    .table_q(tq1), .mismatch(mis1), .pass(pass1)
  );
  task automatic cyc;
    @(posedge clk);
    #1;
  endtask
  task automatic test_reset;
    rst_n = 0;
    cyc();
    cyc();
    tests++; if ({ga, gb, busy, done, pass} !== 5'b0) begin fails++; $display("FAIL reset_ctl: got %b want 00000", {ga, gb, busy, done, pass}); end
    tests++; if ({tq, mis} !== 8'h00) begin fails++; $display("FAIL reset_tbl: got %b want 00000000", {tq, mis}); end
    tests++; if ({ga1, gb1, busy1, done1, pass1, tq1, mis1} !== 13'b0) begin fails++; $display("FAIL reset_dut1: got %b want 0", {ga1, gb1, busy1, done1, pass1, tq1, mis1}); end
    rst_n = 1;
    cyc();
  endtask
  task automatic test_and;
    logic [1:0] w;
    gfn = 0; expected = 4'b1000;
    start = 1; cyc(); start = 0;
    for (int c = 0; c < 8; c++) begin
      w = 2'(c >> 1);
      tests++; if ({busy, done, gb, ga} !== {2'b10, w[1], w[0]}) begin fails++; $display("FAIL and_seq c=%0d: busy,done,b,a got %b want %b", c, {busy, done, gb, ga}, {2'b10, w[1], w[0]}); end
      cyc();
    end
    tests++; if ({busy, done} !== 2'b11) begin fails++; $display("FAIL and_done: busy,done got %b want 11", {busy, done}); end
    tests++; if (tq !== 4'b1000) begin fails++; $display("FAIL and_table: got %b want 1000", tq); end
    tests++; if ({pass, mis} !== 5'b10000) begin fails++; $display("FAIL and_pass: pass,mis got %b want 10000", {pass, mis}); end
    cyc();
    tests++; if ({busy, done, gb, ga} !== 4'b0) begin fails++; $display("FAIL and_end: busy,done,b,a got %b want 0000", {busy, done, gb, ga}); end
  endtask
  task automatic test_or;
    int n;
    gfn = 1; expected = 4'b1000; n = 0;
    start = 1; cyc(); start = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) n++;
      cyc();
    end
    tests++; if (n != 1) begin fails++; $display("FAIL or_done_cnt: got %0d want 1", n); end
    tests++; if (tq !== 4'b1110) begin fails++; $display("FAIL or_table: got %b want 1110", tq); end
    tests++; if (mis !== 4'b0110) begin fails++; $display("FAIL or_mismatch: got %b want 0110", mis); end
    tests++; if (pass !== 1'b0) begin fails++; $display("FAIL or_pass: got %b want 0", pass); end
  endtask
  task automatic test_dwell1;
    int nb, at;
    expected = 4'b0110; nb = 0; at = -1;
    start1 = 1; cyc(); start1 = 0;
    for (int c = 0; c < 10; c++) begin
      if (busy1) nb++;
      if (done1) at = c;
      cyc();
    end
    tests++; if (nb != 5) begin fails++; $display("FAIL d1_busy_len: got %0d want 5", nb); end
    tests++; if (at != 4) begin fails++; $display("FAIL d1_done_at: got %0d want 4", at); end
    tests++; if (tq1 !== 4'b0110) begin fails++; $display("FAIL d1_table: got %b want 0110", tq1); end
    tests++; if ({pass1, mis1} !== 5'b10000) begin fails++; $display("FAIL d1_pass: pass,mis got %b want 10000", {pass1, mis1}); end
  endtask
  task automatic test_abort;
    int n;
    gfn = 1; expected = 4'b1000;
    start = 1; cyc(); start = 0;
    repeat (4) cyc();
    tests++; if ({busy, gb, ga, tq} !== 7'b1100010) begin fails++; $display("FAIL ab_pre: busy,b,a,table got %b want 1100010", {busy, gb, ga, tq}); end
    abort = 1; cyc(); abort = 0;
    tests++; if ({busy, done, gb, ga} !== 4'b0) begin fails++; $display("FAIL ab_idle: busy,done,b,a got %b want 0000", {busy, done, gb, ga}); end
    tests++; if ({tq, pass, mis} !== 9'b001000000) begin fails++; $display("FAIL ab_results: table,pass,mis got %b want 001000000", {tq, pass, mis}); end
    n = 0;
    for (int c = 0; c < 10; c++) begin
      if (busy || done) n++;
      cyc();
    end
    tests++; if (n != 0) begin fails++; $display("FAIL ab_quiet: active cycles got %0d want 0", n); end
    start = 1; abort = 1; cyc(); start = 0; abort = 0;
    tests++; if ({busy, tq} !== 5'b00010) begin fails++; $display("FAIL ab_start_abort: busy,table got %b want 00010", {busy, tq}); end
    cyc();
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ab_start_abort2: busy got %b want 0", busy); end
  endtask
  task automatic test_ignored;
    int n;
    gfn = 0; expected = 4'b1000; n = 0;
    start = 1; cyc(); start = 0;
    for (int c = 0; c < 20; c++) begin
      if (done) n++;
      if (c == 3) start = 1;
      if (c == 4) begin start = 0; expected = 4'b0111; end
      if (c == 8) start = 1;
      if (c == 9) start = 0;
      cyc();
    end
    tests++; if (n != 1) begin fails++; $display("FAIL ign_done_cnt: got %0d want 1", n); end
    tests++; if (busy !== 1'b0) begin fails++; $display("FAIL ign_busy: got %b want 0", busy); end
    tests++; if ({tq, pass, mis} !== 9'b100010000) begin fails++; $display("FAIL ign_results: table,pass,mis got %b want 100010000", {tq, pass, mis}); end
  endtask
  task automatic test_reset_mid;
    int n;
    gfn = 0; expected = 4'b1000;
    start = 1; cyc(); start = 0;
    repeat (3) cyc();
    tests++; if ({busy, gb, ga} !== 3'b101) begin fails++; $display("FAIL rm_pre: busy,b,a got %b want 101", {busy, gb, ga}); end
    #1 rst_n = 0;
    #1;
    tests++; if ({ga, gb, busy, done, pass, tq, mis} !== 13'b0) begin fails++; $display("FAIL rm_async: got %b want 0", {ga, gb, busy, done, pass, tq, mis}); end
    cyc(); rst_n = 1; cyc();
    n = 0;
    start = 1; cyc(); start = 0;
    for (int c = 0; c < 12; c++) begin
      if (done) n++;
      cyc();
    end
    tests++; if (n != 1) begin fails++; $display("FAIL rm_done_cnt: got %0d want 1", n); end
    tests++; if ({tq, pass, mis} !== 9'b100010000) begin fails++; $display("FAIL rm_results: table,pass,mis got %b want 100010000", {tq, pass, mis}); end
  endtask
  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end
  initial begin
    test_reset();
    test_and();
    test_or();
    test_dwell1();
    test_abort();
    test_ignored();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
